tictactoe_nxn_scan: RTL

- Parametrised successor of the 3x3 tic-tac-toe controller: N x N board, K-in-a-row win, two players (X=1, O=0).
- Win detection is a sequential scanner, one anchor cell per cycle, instead of a flat combinational trey check.
- Moves are rejected when `sel_pos` is empty, multi-hot or occupied.
- Flash timing comes from an internal divider on `clk`; there is no separate `flash_clk`.
- Drives the board LEDs and an ASCII status character for the display path.

---
 rtl/tictactoe_nxn_scan_if.sv | 33 +++
 rtl/tictactoe_nxn_scan.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/tictactoe_nxn_scan_if.sv
// Player-side bundle for the N x N tic-tac-toe controller: move inputs, status and LED outputs.
// Latency: none; plain wires between the player panel and the controller.
// Backpressure: none; the controller ignores buttons while busy, so the panel simply re-presses.
interface tictactoe_nxn_scan_if #(
  parameter int N = 3
);
  localparam int CELLS = N * N;
  localparam int MCW   = $clog2(CELLS + 1);

  logic [CELLS-1:0] sel_pos;
  logic             buttonX;
  logic             buttonO;
  logic             turnX;
  logic             turnO;
  logic             busy;
  logic [CELLS-1:0] occ_square;
  logic [CELLS-1:0] occ_player;
  logic [CELLS-1:0] occ_pos;
  logic [MCW-1:0]   move_count;
  logic [7:0]       game_st_ascii;

  // Player panel / testbench side
  modport master (
    output sel_pos, buttonX, buttonO,
    input  turnX, turnO, busy, occ_square, occ_player, occ_pos, move_count, game_st_ascii
  );

  // Game controller side
  modport slave (
    input  sel_pos, buttonX, buttonO,
    output turnX, turnO, busy, occ_square, occ_player, occ_pos, move_count, game_st_ascii
  );
endinterface

// File: rtl/tictactoe_nxn_scan.sv
// N x N, K-in-a-row tic-tac-toe controller with a sequential one-anchor-per-cycle win scanner.
// Latency: move check 1 cycle, win scan 1..N*N cycles; board/status outputs are registered.
// Backpressure: buttons are ignored while busy (CHKV/SCAN) and in terminal states.
module tictactoe_nxn_scan #(
  parameter int N         = 3,
  parameter int K         = 3,
  parameter int FLASH_DIV = 12500000
) (
  input logic             clk,
  input logic             reset,
  tictactoe_nxn_scan_if.slave bus
);

  localparam int CELLS = N * N;
  localparam int MCW   = $clog2(CELLS + 1);
  localparam int IW    = $clog2(CELLS);
  localparam int FCW   = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;

  localparam logic [7:0] ASC_N = 8'h6E;
  localparam logic [7:0] ASC_E = 8'h45;
  localparam logic [7:0] ASC_X = 8'h58;
  localparam logic [7:0] ASC_O = 8'h4F;
  localparam logic [7:0] ASC_C = 8'h43;

  // Out-of-range board geometry is rejected at elaboration
  if (N < 3 || N > 8 || K < 3 || K > N || FLASH_DIV < 1) begin : g_param_check
    $error("tictactoe_nxn_scan: illegal parameters N=%0d K=%0d FLASH_DIV=%0d", N, K, FLASH_DIV);
  end

  typedef enum logic [3:0] {
    START, TURN_X, ERR_X, CHKV_X, SCAN_X, WIN_X,
    TURN_O, ERR_O, CHKV_O, SCAN_O, WIN_O, CATS
  } state_t;

  state_t           state, state_d;
  logic [7:0]       ascii, ascii_d;
  logic [CELLS-1:0] occ_square, occ_square_d;
  logic [CELLS-1:0] occ_player, occ_player_d;
  logic [CELLS-1:0] win_mask, win_mask_d;
  logic [MCW-1:0]   move_count, move_count_d;
  logic [IW-1:0]    scan_idx, scan_idx_d;
  logic [FCW-1:0]   flash_cnt;
  logic [1:0]       phase;

  logic [CELLS-1:0] own;
  logic [CELLS-1:0] x_tiles;
  logic [CELLS-1:0] o_tiles;
  logic             sel_ok;
  logic             scan_last;
  logic             hit;
  logic [CELLS-1:0] hit_mask;

  // K cells starting at anchor, stepping by step; caller guarantees all are on the board
  function automatic logic [CELLS-1:0] run_mask(input int anchor, input int step);
    logic [CELLS-1:0] m;
    m = '0;
    for (int k = 0; k < K; k++) begin
      m = m | (CELLS'(1) << (anchor + k * step));
    end
    return m;
  endfunction

  assign x_tiles   = occ_square & occ_player;
  assign o_tiles   = occ_square & ~occ_player;
  assign own       = (state == SCAN_X) ? x_tiles : o_tiles;
  assign sel_ok    = $onehot(bus.sel_pos) && ((bus.sel_pos & occ_square) == '0);
  assign scan_last = (scan_idx == IW'(CELLS - 1));

  // Test the current anchor in +col, +row, +row+col, +row-col order; first hit wins
  always_comb begin
    int               anchor;
    int               r;
    int               c;
    logic             col_ok;
    logic             row_ok;
    logic             back_ok;
    logic [CELLS-1:0] m;
    anchor   = int'(scan_idx);
    r        = anchor / N;
    c        = anchor % N;
    col_ok   = (c + K - 1) <= (N - 1);
    row_ok   = (r + K - 1) <= (N - 1);
    back_ok  = (c - (K - 1)) >= 0;
    hit      = 1'b0;
    hit_mask = '0;
    m        = '0;
    if (col_ok) begin
      m = run_mask(anchor, 1);
      if ((own & m) == m) begin
        hit      = 1'b1;
        hit_mask = m;
      end
    end
    if (!hit && row_ok) begin
      m = run_mask(anchor, N);
      if ((own & m) == m) begin
        hit      = 1'b1;
        hit_mask = m;
      end
    end
    if (!hit && row_ok && col_ok) begin
      m = run_mask(anchor, N + 1);
      if ((own & m) == m) begin
        hit      = 1'b1;
        hit_mask = m;
      end
    end
    if (!hit && row_ok && back_ok) begin
      m = run_mask(anchor, N - 1);
      if ((own & m) == m) begin
        hit      = 1'b1;
        hit_mask = m;
      end
    end
  end

  // Game FSM: turn handling, move validation, board update and scan sequencing
  always_comb begin
    state_d      = state;
    ascii_d      = ascii;
    occ_square_d = occ_square;
    occ_player_d = occ_player;
    win_mask_d   = win_mask;
    move_count_d = move_count;
    scan_idx_d   = scan_idx;
    case (state)
      START: state_d = TURN_X;
      TURN_X: begin
        if (bus.buttonO) begin
          state_d = ERR_X;
          ascii_d = ASC_E;
        end else if (bus.buttonX) begin
          state_d = CHKV_X;
        end
      end
      ERR_X: begin
        if (bus.buttonX) begin
          state_d = CHKV_X;
          ascii_d = ASC_N;
        end
      end
      TURN_O: begin
        if (bus.buttonX) begin
          state_d = ERR_O;
          ascii_d = ASC_E;
        end else if (bus.buttonO) begin
          state_d = CHKV_O;
        end
      end
      ERR_O: begin
        if (bus.buttonO) begin
          state_d = CHKV_O;
          ascii_d = ASC_N;
        end
      end
      CHKV_X, CHKV_O: begin
        if (sel_ok) begin
          occ_square_d = occ_square | bus.sel_pos;
          if (state == CHKV_X) occ_player_d = occ_player | bus.sel_pos;
          move_count_d = move_count + 1'b1;
          scan_idx_d   = '0;
          state_d      = (state == CHKV_X) ? SCAN_X : SCAN_O;
        end else begin
          state_d = (state == CHKV_X) ? ERR_X : ERR_O;
          ascii_d = ASC_E;
        end
      end
      SCAN_X, SCAN_O: begin
        if (hit) begin
          win_mask_d = hit_mask;
          state_d    = (state == SCAN_X) ? WIN_X : WIN_O;
          ascii_d    = (state == SCAN_X) ? ASC_X : ASC_O;
        end else if (!scan_last) begin
          scan_idx_d = scan_idx + 1'b1;
        end else if (move_count == MCW'(CELLS)) begin
          state_d = CATS;
          ascii_d = ASC_C;
        end else begin
          state_d = (state == SCAN_X) ? TURN_O : TURN_X;
          ascii_d = ASC_N;
        end
      end
      WIN_X, WIN_O, CATS: ;
      default: state_d = START;
    endcase
  end

  // Game state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= START;
      ascii      <= ASC_N;
      occ_square <= '0;
      occ_player <= '0;
      win_mask   <= '0;
      move_count <= '0;
      scan_idx   <= '0;
    end else begin
      state      <= state_d;
      ascii      <= ascii_d;
      occ_square <= occ_square_d;
      occ_player <= occ_player_d;
      win_mask   <= win_mask_d;
      move_count <= move_count_d;
      scan_idx   <= scan_idx_d;
    end
  end

  // Flash divider: phase[0] is the fast O blink, phase[1] the slow win blink
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flash_cnt <= '0;
      phase     <= '0;
    end else if (flash_cnt == FCW'(FLASH_DIV - 1)) begin
      flash_cnt <= '0;
      phase     <= phase + 2'd1;
    end else begin
      flash_cnt <= flash_cnt + 1'b1;
    end
  end

  assign bus.turnX         = (state == TURN_X) || (state == ERR_X);
  assign bus.turnO         = (state == TURN_O) || (state == ERR_O);
  assign bus.busy          = (state == CHKV_X) || (state == SCAN_X) ||
                             (state == CHKV_O) || (state == SCAN_O);
  assign bus.occ_square    = occ_square;
  assign bus.occ_player    = occ_player;
  assign bus.move_count    = move_count;
  assign bus.game_st_ascii = ascii;
  assign bus.occ_pos       = (win_mask & {CELLS{phase[1]}}) |
                             (~win_mask & (x_tiles | (o_tiles & {CELLS{phase[0]}})));

endmodule
